mult_seq_ctrl: RTL and testbench

Sequencing controller that computes an N×N unsigned product by time-multiplexing one shared (N/2)×(N/2) sub-multiplier over four quadrant products. It collects the four partial products into registers, drives them into the existing four-input partial-product adder, and registers that adder's 2N-bit result. It sits between an upstream valid/ready operand source and a downstream valid/ready result sink.

---
 rtl/mult_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// N x N unsigned multiply sequencer: issues four quadrant products through one shared
// (N/2)x(N/2) sub-multiplier, collects them, and registers the external adder's sum.
module mult_seq_ctrl #(
  parameter int N       = 8,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [N/2-1:0]   mul_x,
  output logic [N/2-1:0]   mul_y,
  input  logic [N-1:0]     mul_p,
  output logic [N-1:0]     prod1,
  output logic [N-1:0]     prod2,
  output logic [N-1:0]     prod3,
  output logic [N-1:0]     prod4,
  input  logic [2*N-1:0]   sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_prod,
  output logic             busy
);

  localparam int H = N / 2;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SUM, DONE} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] a_r, b_r;
  logic [1:0]   k;
  logic         issue;
  logic         cap_vld;
  logic [1:0]   cap_k;
  logic         last_cap;

  assign issue    = (state == ISSUE);
  assign last_cap = cap_vld && (cap_k == 2'd3);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    mul_x     = '0;
    mul_y     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        // k[0] picks the high half of A, k[1] the high half of B
        mul_x = k[0] ? a_r[N-1:H] : a_r[H-1:0];
        mul_y = k[1] ? b_r[N-1:H] : b_r[H-1:0];
        if (k == 2'd3) state_nxt = (MUL_LAT == 0) ? SUM : DRAIN;
      end
      DRAIN: if (last_cap) state_nxt = SUM;
      SUM:   state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue-tag delay line: aligns each quadrant index with its product on mul_p
  generate
    if (MUL_LAT == 0) begin : g_nolat
      assign cap_vld = issue;
      assign cap_k   = k;
    end else begin : g_tag
      logic [MUL_LAT-1:0] tag_vld_p;
      logic [1:0]         tag_k_p [MUL_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_vld_p <= '0;
          for (int i = 0; i < MUL_LAT; i++) tag_k_p[i] <= '0;
        end else begin
          tag_vld_p[0] <= issue;
          tag_k_p[0]   <= k;
          for (int i = 1; i < MUL_LAT; i++) begin
            tag_vld_p[i] <= tag_vld_p[i-1];
            tag_k_p[i]   <= tag_k_p[i-1];
          end
        end
      end

      assign cap_vld = tag_vld_p[MUL_LAT-1];
      assign cap_k   = tag_k_p[MUL_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      k        <= '0;
      prod1    <= '0;
      prod2    <= '0;
      prod3    <= '0;
      prod4    <= '0;
      out_prod <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        a_r <= in_a;
        b_r <= in_b;
        k   <= '0;
      end else if (issue) begin
        k <= k + 2'd1;
      end
      if (cap_vld) begin
        case (cap_k)
          2'd0:    prod1 <= mul_p;
          2'd1:    prod2 <= mul_p;
          2'd2:    prod3 <= mul_p;
          default: prod4 <= mul_p;
        endcase
      end
      if (state == SUM) out_prod <= sum_in;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: three instances (MUL_LAT 0,1,2), each with its own
// sub-multiplier delay line and partial-product adder model.
module tb_mult_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] in_a      [3];
  logic [7:0] in_b      [3];
  logic [3:0] mul_x     [3];
  logic [3:0] mul_y     [3];
  logic [7:0] mul_p     [3];
  logic [7:0] p1 [3], p2 [3], p3 [3], p4 [3];
  logic [15:0] sum_in   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [15:0] out_prod [3];
  logic       busy      [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DI = (g == 0) ? 0 : g - 1;
    logic [7:0] dl [4];

    mult_seq_ctrl #(.N(8), .MUL_LAT(g)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]),
      .mul_x(mul_x[g]), .mul_y(mul_y[g]), .mul_p(mul_p[g]),
      .prod1(p1[g]), .prod2(p2[g]), .prod3(p3[g]), .prod4(p4[g]),
      .sum_in(sum_in[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_prod(out_prod[g]), .busy(busy[g])
    );

    always @(posedge clk) begin
      dl[0] <= {4'b0, mul_x[g]} * {4'b0, mul_y[g]};
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end

    assign mul_p[g]  = (g == 0) ? ({4'b0, mul_x[g]} * {4'b0, mul_y[g]}) : dl[DI];
    assign sum_in[g] = {8'b0, p1[g]} + ({8'b0, p2[g]} << 4) + ({8'b0, p3[g]} << 4)
                     + {p4[g], 8'b0};
  end

  // Quadrant operand monitor for the MUL_LAT=1 instance
  logic       mon_en = 1'b0;
  logic [7:0] mon_q [$];
  always @(negedge clk)
    if (mon_en && (mul_x[1] != 0 || mul_y[1] != 0)) mon_q.push_back({mul_x[1], mul_y[1]});

  typedef struct {
    logic [7:0]  a, b;
    logic [15:0] p;
    logic [7:0]  q1, q2, q3, q4;
  } vec_t;
  vec_t vt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Accept one operand pair, wait for the result; lat counts edges from the accept edge
  task automatic run_op(input int g, input logic [7:0] a, input logic [7:0] b,
                        input logic rdy, output logic [15:0] p, output int lat);
    int n = 0;
    out_ready[g] = rdy;
    @(negedge clk);
    while (!in_ready[g] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    in_valid[g] = 1'b1;
    in_a[g] = a;
    in_b[g] = b;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    in_a[g] = 8'($urandom);
    in_b[g] = 8'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid[g] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    p = out_prod[g];
  endtask

  logic [15:0] p;
  int          lat;
  logic [7:0]  a, b;

  initial begin
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0;
      in_a[g] = '0;
      in_b[g] = '0;
      out_ready[g] = 1'b1;
    end

    vt[0] = '{a: 8'hB7, b: 8'h5C, p: 16'h41C4, q1: 8'h54, q2: 8'h84, q3: 8'h23, q4: 8'h37};
    vt[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01, q1: 8'hE1, q2: 8'hE1, q3: 8'hE1, q4: 8'hE1};
    vt[2] = '{a: 8'h00, b: 8'hA5, p: 16'h0000, q1: 8'h00, q2: 8'h00, q3: 8'h00, q4: 8'h00};
    vt[3] = '{a: 8'h12, b: 8'h34, p: 16'h03A8, q1: 8'h08, q2: 8'h04, q3: 8'h06, q4: 8'h03};

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid[1], 0);
    chk("rst_busy", busy[1], 0);
    chk("rst_out_prod", out_prod[1], 0);
    chk("rst_prods", {p1[1], p2[1], p3[1], p4[1]}, 0);
    chk("rst_mul_xy", {mul_x[1], mul_y[1]}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready[1], 1);

    // Directed vectors, MUL_LAT=1; quadrant order checked on the first
    for (int i = 0; i < 4; i++) begin
      mon_q.delete();
      mon_en = (i == 0);
      run_op(1, vt[i].a, vt[i].b, 1'b1, p, lat);
      mon_en = 1'b0;
      chk($sformatf("vec%0d_prod", i), p, vt[i].p);
      chk($sformatf("vec%0d_lat", i), lat, 7);
      chk($sformatf("vec%0d_p1", i), p1[1], vt[i].q1);
      chk($sformatf("vec%0d_p2", i), p2[1], vt[i].q2);
      chk($sformatf("vec%0d_p3", i), p3[1], vt[i].q3);
      chk($sformatf("vec%0d_p4", i), p4[1], vt[i].q4);
      chk($sformatf("vec%0d_busy_done", i), busy[1], 1);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_1cyc", i), out_valid[1], 0);
      chk($sformatf("vec%0d_idle_busy", i), busy[1], 0);
      if (i == 0) begin
        chk("mon_count", mon_q.size(), 4);
        if (mon_q.size() == 4) begin
          chk("mon_lolo", mon_q[0], {vt[0].a[3:0], vt[0].b[3:0]});
          chk("mon_hilo", mon_q[1], {vt[0].a[7:4], vt[0].b[3:0]});
          chk("mon_lohi", mon_q[2], {vt[0].a[3:0], vt[0].b[7:4]});
          chk("mon_hihi", mon_q[3], {vt[0].a[7:4], vt[0].b[7:4]});
        end
      end
    end

    // Backpressure: result held 5 cycles, in_valid pulse ignored
    run_op(1, 8'hB7, 8'h5C, 1'b0, p, lat);
    chk("bp_lat", lat, 7);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        in_valid[1] = 1'b1;
        in_a[1] = 8'h12;
        in_b[1] = 8'h34;
      end else begin
        in_valid[1] = 1'b0;
      end
      @(negedge clk);
      chk("bp_valid", out_valid[1], 1);
      chk("bp_prod", out_prod[1], 16'h41C4);
      chk("bp_in_ready", in_ready[1], 0);
    end
    in_valid[1] = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid[1], 0);
    chk("bp_release_ready", in_ready[1], 1);
    run_op(1, 8'h12, 8'h34, 1'b1, p, lat);
    chk("bp_next_prod", p, 16'h03A8);

    // Latency sweep
    run_op(0, 8'hB7, 8'h5C, 1'b1, p, lat);
    chk("lat0_prod", p, 16'h41C4);
    chk("lat0_lat", lat, 6);
    run_op(2, 8'hB7, 8'h5C, 1'b1, p, lat);
    chk("lat2_prod", p, 16'h41C4);
    chk("lat2_lat", lat, 8);

    // Random back-to-back operations against a*b
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 67; i++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        run_op(g, a, b, 1'b1, p, lat);
        chk($sformatf("rnd%0d_prod a=%0h b=%0h", g, a, b), p, 16'(a) * 16'(b));
        chk($sformatf("rnd%0d_lat", g), lat, 6 + g);
        chk($sformatf("rnd%0d_p4", g), p4[g], 8'(a[7:4] * b[7:4]));
      end
    end

    // Asynchronous reset during ISSUE k=2
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_a[1] = 8'hB7;
    in_b[1] = 8'h5C;
    @(posedge clk);
    #1 in_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("midrst_k2_xy", {mul_x[1], mul_y[1]}, {4'h7, 4'h5});
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy[1], 0);
    chk("midrst_valid", out_valid[1], 0);
    chk("midrst_xy", {mul_x[1], mul_y[1]}, 0);
    chk("midrst_prods", {p1[1], p2[1], p3[1], p4[1]}, 0);
    chk("midrst_out_prod", out_prod[1], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready[1], 1);
    run_op(1, 8'h03, 8'h04, 1'b1, p, lat);
    chk("midrst_next_prod", p, 16'h000C);
    chk("midrst_next_prods", {p1[1], p2[1], p3[1], p4[1]}, 32'h0C000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
